// File: rtl/hood_mode_fsm_v2.sv
// Range-hood mode state machine with a seconds-resolution countdown engine.
// It sits between the button press classifier and the display/fan-drive logic.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   power_short    - short press of power/menu (1-cycle pulse)
//   power_long     - long press of power/menu (1-cycle pulse)
//   lvl1_press     - level-1 key (1-cycle pulse)
//   lvl2_press     - level-2 key (1-cycle pulse)
//   storm_press    - level-3 (storm) key (1-cycle pulse)
//   clean_press    - self-clean key (1-cycle pulse)
//   state          - current state, registered
//   fan_level      - decode of state (combinational)
//   remaining_sec  - seconds left in a timed state, 0 otherwise
//   storm_used     - storm has been entered during this power cycle
//   clean_done     - 1-cycle pulse when self-clean completes normally
module hood_mode_fsm_v2 #(
   parameter int unsigned TICKS_PER_SEC  = 100000000,
   parameter int unsigned SEC_W          = 8,
   parameter int unsigned STORM_SEC      = 60,
   parameter int unsigned CLEAN_SEC      = 180,
   parameter int unsigned EXIT_DELAY_SEC = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             power_short,
   input  logic             power_long,
   input  logic             lvl1_press,
   input  logic             lvl2_press,
   input  logic             storm_press,
   input  logic             clean_press,
   output logic [2:0]       state,
   output logic [1:0]       fan_level,
   output logic [SEC_W-1:0] remaining_sec,
   output logic             storm_used,
   output logic             clean_done
);

   localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      S_OFF         = 3'd0,
      S_STANDBY     = 3'd1,
      S_MODE_SELECT = 3'd2,
      S_LEVEL1      = 3'd3,
      S_LEVEL2      = 3'd4,
      S_STORM       = 3'd5,
      S_SELF_CLEAN  = 3'd6,
      S_STORM_EXIT  = 3'd7
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [PRE_W-1:0] prescaler;
   logic             timed;
   logic             sec_tick;
   logic             timeout;

   // Countdown load value for the state being entered; 0 for untimed states.
   function automatic logic [SEC_W-1:0] dur_of(input state_t s);
      case (s)
         S_STORM:      dur_of = SEC_W'(STORM_SEC);
         S_SELF_CLEAN: dur_of = SEC_W'(CLEAN_SEC);
         S_STORM_EXIT: dur_of = SEC_W'(EXIT_DELAY_SEC);
         default:      dur_of = '0;
      endcase
   endfunction

   assign state    = state_q;
   assign timed    = (state_q == S_STORM) || (state_q == S_SELF_CLEAN) ||
                     (state_q == S_STORM_EXIT);
   assign sec_tick = timed && (prescaler == PRE_MAX);
   // Last second expires on this edge.
   assign timeout  = sec_tick && (remaining_sec == SEC_W'(1));

   // Next-state selection; power_long overrides everything outside OFF.
   always_comb begin
      state_nxt = state_q;
      if (power_long && (state_q != S_OFF)) begin
         state_nxt = S_OFF;
      end else begin
         case (state_q)
            S_OFF:         if (power_short) state_nxt = S_STANDBY;
            S_STANDBY:     if (power_short) state_nxt = S_MODE_SELECT;
            S_MODE_SELECT: begin
               if (lvl1_press)                      state_nxt = S_LEVEL1;
               else if (lvl2_press)                 state_nxt = S_LEVEL2;
               else if (storm_press && !storm_used) state_nxt = S_STORM;
               else if (clean_press)                state_nxt = S_SELF_CLEAN;
            end
            S_LEVEL1: begin
               if (lvl2_press)                      state_nxt = S_LEVEL2;
               else if (storm_press && !storm_used) state_nxt = S_STORM;
               else if (power_short)                state_nxt = S_STANDBY;
            end
            S_LEVEL2: begin
               if (lvl1_press)                      state_nxt = S_LEVEL1;
               else if (storm_press && !storm_used) state_nxt = S_STORM;
               else if (power_short)                state_nxt = S_STANDBY;
            end
            S_STORM: begin
               if (timeout)          state_nxt = S_LEVEL2;
               else if (power_short) state_nxt = S_STORM_EXIT;
            end
            S_SELF_CLEAN: if (timeout) state_nxt = S_STANDBY;
            S_STORM_EXIT: if (timeout) state_nxt = S_STANDBY;
            default:      state_nxt = S_OFF;
         endcase
      end
   end

   // State, countdown and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_OFF;
         prescaler     <= '0;
         remaining_sec <= '0;
         storm_used    <= 1'b0;
         clean_done    <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         // Only a timeout leaves SELF_CLEAN for STANDBY; aborts go to OFF.
         clean_done <= (state_q == S_SELF_CLEAN) && (state_nxt == S_STANDBY);

         if (state_nxt == S_OFF)        storm_used <= 1'b0;
         else if (state_nxt == S_STORM) storm_used <= 1'b1;

         if (state_nxt != state_q) begin
            prescaler     <= '0;
            remaining_sec <= dur_of(state_nxt);
         end else if (timed) begin
            if (sec_tick) begin
               prescaler     <= '0;
               remaining_sec <= remaining_sec - SEC_W'(1);
            end else begin
               prescaler <= prescaler + PRE_W'(1);
            end
         end
      end
   end

   // Fan drive level for the display/fan logic.
   always_comb begin
      fan_level = 2'd0;
      case (state_q)
         S_LEVEL1:                   fan_level = 2'd1;
         S_LEVEL2, S_SELF_CLEAN:     fan_level = 2'd2;
         S_STORM, S_STORM_EXIT:      fan_level = 2'd3;
         default:                    fan_level = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_hood_mode_fsm_v2.sv
// Table-driven bench for hood_mode_fsm_v2 with a small expected-value queue.
module tb_hood_mode_fsm_v2;

   localparam int unsigned SEC_W = 8;

   // Key bit positions in a vector: {power_long, power_short, lvl1, lvl2, storm, clean}
   localparam logic [5:0] K_NO = 6'b000000;
   localparam logic [5:0] K_PL = 6'b100000;
   localparam logic [5:0] K_PS = 6'b010000;
   localparam logic [5:0] K_L1 = 6'b001000;
   localparam logic [5:0] K_L2 = 6'b000100;
   localparam logic [5:0] K_ST = 6'b000010;
   localparam logic [5:0] K_CL = 6'b000001;

   typedef struct packed {
      logic [2:0]       st;
      logic [SEC_W-1:0] rem;
      logic [1:0]       fan;
      logic             su;
      logic             cd;
   } exp_t;

   typedef struct {
      int unsigned cyc;
      logic [5:0]  keys;
      logic        rst;
      exp_t        exp;
   } vec_t;

   logic             clk;
   logic             rst;
   logic             power_short, power_long, lvl1_press, lvl2_press, storm_press, clean_press;
   logic [2:0]       state;
   logic [1:0]       fan_level;
   logic [SEC_W-1:0] remaining_sec;
   logic             storm_used;
   logic             clean_done;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_vec;
   int   n_bad;

   hood_mode_fsm_v2 #(
      .TICKS_PER_SEC (4),
      .SEC_W         (SEC_W),
      .STORM_SEC     (3),
      .CLEAN_SEC     (5),
      .EXIT_DELAY_SEC(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .power_short  (power_short),
      .power_long   (power_long),
      .lvl1_press   (lvl1_press),
      .lvl2_press   (lvl2_press),
      .storm_press  (storm_press),
      .clean_press  (clean_press),
      .state        (state),
      .fan_level    (fan_level),
      .remaining_sec(remaining_sec),
      .storm_used   (storm_used),
      .clean_done   (clean_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic add(input int unsigned cyc, input logic [5:0] keys, input logic r,
                      input int st, input int rem, input int fan, input int su, input int cd);
      vec_t v;
      v.cyc  = cyc;
      v.keys = keys;
      v.rst  = r;
      v.exp  = '{st: 3'(st), rem: SEC_W'(rem), fan: 2'(fan), su: 1'(su), cd: 1'(cd)};
      vecs.push_back(v);
   endtask

   // Inputs change 1 time unit after the rising edge and are sampled at the next one.
   task automatic drive_cycle(input logic [5:0] k, input logic r);
      {power_long, power_short, lvl1_press, lvl2_press, storm_press, clean_press} = k;
      rst = r;
      @(posedge clk);
      #1;
      {power_long, power_short, lvl1_press, lvl2_press, storm_press, clean_press} = K_NO;
      rst = 1'b0;
   endtask

   task automatic check_pop(input int idx);
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{st: state, rem: remaining_sec, fan: fan_level, su: storm_used, cd: clean_done};
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL vec%0d: got state=%0d rem=%0d fan=%0d su=%0b cd=%0b, want state=%0d rem=%0d fan=%0d su=%0b cd=%0b",
                  idx, a.st, a.rem, a.fan, a.su, a.cd, e.st, e.rem, e.fan, e.su, e.cd);
      end
   endtask

   initial begin
      int storm_cycles;
      n_vec = 0;
      n_bad = 0;
      rst   = 1'b1;
      {power_long, power_short, lvl1_press, lvl2_press, storm_press, clean_press} = K_NO;

      // cyc, keys, rst, state, rem, fan, storm_used, clean_done
      add(2,  K_NO, 1, 0, 0, 0, 0, 0);
      // Storm run to timeout
      add(1,  K_PS, 0, 1, 0, 0, 0, 0);
      add(1,  K_PS, 0, 2, 0, 0, 0, 0);
      add(1,  K_ST, 0, 5, 3, 3, 1, 0);
      add(4,  K_NO, 0, 5, 2, 3, 1, 0);
      add(4,  K_NO, 0, 5, 1, 3, 1, 0);
      add(3,  K_NO, 0, 5, 1, 3, 1, 0);
      add(1,  K_NO, 0, 4, 0, 2, 1, 0);
      // Storm lockout, power_long clears it
      add(1,  K_ST, 0, 4, 0, 2, 1, 0);
      add(1,  K_L1, 0, 3, 0, 1, 1, 0);
      add(1,  K_PL, 0, 0, 0, 0, 0, 0);
      add(1,  K_PL, 0, 0, 0, 0, 0, 0);
      add(1,  K_PS, 0, 1, 0, 0, 0, 0);
      add(1,  K_PS, 0, 2, 0, 0, 0, 0);
      add(1,  K_ST, 0, 5, 3, 3, 1, 0);
      // Manual storm exit with delay
      add(4,  K_NO, 0, 5, 2, 3, 1, 0);
      add(1,  K_PS, 0, 7, 2, 3, 1, 0);
      add(7,  K_NO, 0, 7, 1, 3, 1, 0);
      add(1,  K_NO, 0, 1, 0, 0, 1, 0);
      // storm_used still set: storm key ignored
      add(1,  K_PS, 0, 2, 0, 0, 1, 0);
      add(1,  K_ST, 0, 2, 0, 0, 1, 0);
      add(1,  K_L2, 0, 4, 0, 2, 1, 0);
      add(1,  K_ST, 0, 4, 0, 2, 1, 0);
      add(1,  K_L1, 0, 3, 0, 1, 1, 0);
      add(1,  K_L2, 0, 4, 0, 2, 1, 0);
      add(1,  K_PS, 0, 1, 0, 0, 1, 0);
      // Self-clean to completion
      add(1,  K_PS, 0, 2, 0, 0, 1, 0);
      add(1,  K_CL, 0, 6, 5, 2, 1, 0);
      add(19, K_NO, 0, 6, 1, 2, 1, 0);
      add(1,  K_NO, 0, 1, 0, 0, 1, 1);
      add(1,  K_NO, 0, 1, 0, 0, 1, 0);
      // Self-clean aborted by power_long
      add(1,  K_PS, 0, 2, 0, 0, 1, 0);
      add(1,  K_CL, 0, 6, 5, 2, 1, 0);
      add(9,  K_NO, 0, 6, 3, 2, 1, 0);
      add(1,  K_PL, 0, 0, 0, 0, 0, 0);
      add(1,  K_NO, 0, 0, 0, 0, 0, 0);
      // Simultaneous keys
      add(1,  K_PS, 0, 1, 0, 0, 0, 0);
      add(1,  K_PS, 0, 2, 0, 0, 0, 0);
      add(1,  K_L1 | K_L2, 0, 3, 0, 1, 0, 0);
      add(1,  K_PL | K_PS, 0, 0, 0, 0, 0, 0);
      // Timeout and power_short together in STORM: timeout wins
      add(1,  K_PS, 0, 1, 0, 0, 0, 0);
      add(1,  K_PS, 0, 2, 0, 0, 0, 0);
      add(1,  K_ST, 0, 5, 3, 3, 1, 0);
      add(11, K_NO, 0, 5, 1, 3, 1, 0);
      add(1,  K_PS, 0, 4, 0, 2, 1, 0);
      // Reset mid self-clean
      add(1,  K_PS, 0, 1, 0, 0, 1, 0);
      add(1,  K_PS, 0, 2, 0, 0, 1, 0);
      add(1,  K_CL, 0, 6, 5, 2, 1, 0);
      add(5,  K_NO, 0, 6, 4, 2, 1, 0);
      add(1,  K_NO, 1, 0, 0, 0, 0, 0);
      // Timeout and power_long together in SELF_CLEAN: OFF, no clean_done
      add(1,  K_PS, 0, 1, 0, 0, 0, 0);
      add(1,  K_PS, 0, 2, 0, 0, 0, 0);
      add(1,  K_CL, 0, 6, 5, 2, 0, 0);
      add(19, K_NO, 0, 6, 1, 2, 0, 0);
      add(1,  K_PL, 0, 0, 0, 0, 0, 0);
      add(1,  K_NO, 0, 0, 0, 0, 0, 0);
      add(1,  K_PS, 0, 1, 0, 0, 0, 0);
      add(1,  K_PS, 0, 2, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         for (int c = 0; c < int'(vecs[i].cyc); c++) begin
            if (c == 0) begin
               exp_q.push_back(vecs[i].exp);
               drive_cycle(vecs[i].keys, vecs[i].rst);
            end else begin
               drive_cycle(K_NO, 1'b0);
            end
         end
         check_pop(i);
      end

      // Storm must read state 5 for exactly STORM_SEC*TICKS_PER_SEC = 12 cycles.
      drive_cycle(K_ST, 1'b0);
      storm_cycles = (state == 3'd5) ? 1 : 0;
      for (int c = 0; c < 40 && state == 3'd5; c++) begin
         drive_cycle(K_NO, 1'b0);
         if (state == 3'd5) storm_cycles++;
      end
      n_vec++;
      if (storm_cycles != 12) begin
         n_bad++;
         $display("FAIL storm_len: got %0d cycles in STORM, want 12", storm_cycles);
      end
      n_vec++;
      if (state !== 3'd4 || remaining_sec !== SEC_W'(0)) begin
         n_bad++;
         $display("FAIL storm_end: got state=%0d rem=%0d, want state=4 rem=0", state, remaining_sec);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
